// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC selection for the single-cycle core.
// A three-state fetch FSM (boot bubble, run, wait-for-imem) decides when the pc advances.
// Optional feature macro: BRANCH_STATS_EN adds the br_cnt / taken_cnt branch counters.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        branch,
    input  logic        bne,
    input  logic        zero,
    input  logic        bz_branch,
    input  logic        less_or_greater,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] imm,
    input  logic [25:0] jaddr,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        branch_taken,
`ifdef BRANCH_STATS_EN
    output logic        misalign,
    output logic [31:0] br_cnt,
    output logic [31:0] taken_cnt
`else
    output logic        misalign
`endif
);

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StWait = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        branch_taken_q, branch_taken_d;
    logic        misalign_q, misalign_d;

    logic        advance;
    logic        taken;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;
    assign taken    = (branch & (zero ^ bne)) | (bz_branch & less_or_greater);

    // Next-PC selection: jr beats jump beats a taken branch beats sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = {rs_data[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jaddr, 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + {imm[29:0], 2'b00};
        end
    end

    // Fetch FSM next state, advance decision and register next-state values.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        branch_taken_d = branch_taken_q;
        misalign_d     = misalign_q;
        advance        = 1'b0;
        fetch_valid    = 1'b0;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                fetch_valid = 1'b1;
                advance     = imem_ready & ~stall;
                if (!imem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                fetch_valid = 1'b1;
                // The word arriving here only re-enters RUN; the advance happens next cycle.
                if (imem_ready) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
        if (advance) begin
            pc_d           = next_pc;
            branch_taken_d = jr | jump | taken;
            misalign_d     = jr & (|rs_data[1:0]);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StBoot;
            pc_q           <= RESET_PC;
            branch_taken_q <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            branch_taken_q <= branch_taken_d;
            misalign_q     <= misalign_d;
        end
    end

    assign pc           = pc_q;
    assign branch_taken = branch_taken_q;
    assign misalign     = misalign_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_cnt_q, taken_cnt_q;

    // Branch statistics: a taken condition counts even when a jump overrides the target.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q    <= 32'd0;
            taken_cnt_q <= 32'd0;
        end else if (advance) begin
            if (branch | bz_branch) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (taken) begin
                taken_cnt_q <= taken_cnt_q + 32'd1;
            end
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit; define BRANCH_STATS_EN to also check the counters.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst, stall, imem_ready, branch, bne, zero, bz_branch, less_or_greater;
    logic        jump, jr;
    logic [31:0] imm, rs_data;
    logic [25:0] jaddr;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, branch_taken, misalign;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_cnt, taken_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .imem_ready      (imem_ready),
        .branch          (branch),
        .bne             (bne),
        .zero            (zero),
        .bz_branch       (bz_branch),
        .less_or_greater (less_or_greater),
        .jump            (jump),
        .jr              (jr),
        .imm             (imm),
        .jaddr           (jaddr),
        .rs_data         (rs_data),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .fetch_valid     (fetch_valid),
        .branch_taken    (branch_taken),
`ifdef BRANCH_STATS_EN
        .misalign        (misalign),
        .br_cnt          (br_cnt),
        .taken_cnt       (taken_cnt)
`else
        .misalign        (misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        branch = 0; bne = 0; zero = 0; bz_branch = 0; less_or_greater = 0;
        jump = 0; jr = 0; imm = '0; jaddr = '0; rs_data = '0; stall = 0;
    endtask

    initial begin
        clear_ctrl();
        rst = 1; imem_ready = 1;
        // T1: reset then boot bubble then sequential fetch
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_fv", {31'd0, fetch_valid}, 32'd0);
        check("rst_bt", {31'd0, branch_taken}, 32'd0);
        check("rst_mis", {31'd0, misalign}, 32'd0);
        rst = 0;
        step();
        check("boot_pc", pc, 32'h0);
        check("run_fv", {31'd0, fetch_valid}, 32'd1);
        check("pc_plus4", pc_plus4, 32'h4);
        step(); check("seq4", pc, 32'h4);
        step(); check("seq8", pc, 32'h8);

        // get to 0x100 via jr
        jr = 1; rs_data = 32'h100;
        step(); check("jr100", pc, 32'h100); check("jr_bt", {31'd0, branch_taken}, 32'd1);
        check("jr_mis0", {31'd0, misalign}, 32'd0);
        clear_ctrl();

        // T2: beq taken backwards: 0x104 + (-8) = 0xFC
        branch = 1; zero = 1; imm = 32'hFFFF_FFFE;
        step(); check("beq_back", pc, 32'hFC); check("beq_bt", {31'd0, branch_taken}, 32'd1);
        clear_ctrl();
        step(); check("seq100", pc, 32'h100); check("seq_bt0", {31'd0, branch_taken}, 32'd0);

        // T3: jump beats taken bz branch: {0x0, 0x40, 00} = 0x100
        bz_branch = 1; less_or_greater = 1; jump = 1; jaddr = 26'h40; imm = 32'h10;
        step(); check("jump_wins", pc, 32'h100);
        clear_ctrl();

        // bne with zero=1 is not taken
        branch = 1; bne = 1; zero = 1; imm = 32'h4;
        step(); check("bne_nt", pc, 32'h104); check("bne_nt_bt", {31'd0, branch_taken}, 32'd0);
`ifdef BRANCH_STATS_EN
        check("br_cnt3", br_cnt, 32'd3);
        check("taken_cnt2", taken_cnt, 32'd2);
`endif
        // bne with zero=0 taken: 0x108 + 0x10 = 0x118
        zero = 0;
        step(); check("bne_t", pc, 32'h118); check("bne_t_bt", {31'd0, branch_taken}, 32'd1);
        clear_ctrl();

        // T4: misaligned jr target
        jr = 1; rs_data = 32'h203;
        step(); check("jr_mis_pc", pc, 32'h200); check("jr_mis", {31'd0, misalign}, 32'd1);
        clear_ctrl();
        step(); check("mis_clr_pc", pc, 32'h204); check("mis_clr", {31'd0, misalign}, 32'd0);

        // T5: WAIT on imem_ready=0
        jr = 1; rs_data = 32'h20;
        step(); check("jr20", pc, 32'h20);
        clear_ctrl();
        imem_ready = 0;
        step(); check("wait1_pc", pc, 32'h20); check("wait_fv", {31'd0, fetch_valid}, 32'd1);
        step(); check("wait2_pc", pc, 32'h20);
        imem_ready = 1;
        step(); check("wait_exit_pc", pc, 32'h20);
        step(); check("after_wait", pc, 32'h24);

        // T6: sequential wrap
        jr = 1; rs_data = 32'hFFFF_FFFC;
        step(); check("jr_top", pc, 32'hFFFF_FFFC);
        clear_ctrl();
        step(); check("wrap0", pc, 32'h0);
        // stall holds pc and flags even with jr pending
        jr = 1; rs_data = 32'h41;
        step(); check("jr41", pc, 32'h40);
        rs_data = 32'h80; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_pc", pc, 32'h40);
        end
        check("stall_bt", {31'd0, branch_taken}, 32'd1);
        check("stall_mis", {31'd0, misalign}, 32'd1);
        clear_ctrl();
        step(); check("unstall", pc, 32'h44); check("unstall_mis", {31'd0, misalign}, 32'd0);

        // branch target wraps: pc=4, 8 + (-16) = 0xFFFFFFF8
        jr = 1; rs_data = 32'h4;
        step(); check("jr4", pc, 32'h4);
        clear_ctrl();
        branch = 1; zero = 1; imm = 32'hFFFF_FFFC;
        step(); check("br_wrap", pc, 32'hFFFF_FFF8);
        clear_ctrl();
`ifdef BRANCH_STATS_EN
        check("br_cnt5", br_cnt, 32'd5);
        check("taken_cnt4", taken_cnt, 32'd4);
`endif

        // reset during WAIT returns to BOOT
        imem_ready = 0;
        step(); check("pre_rst_wait", pc, 32'hFFFF_FFF8);
        rst = 1;
        step(); check("rst_wait_pc", pc, 32'h0); check("rst_wait_fv", {31'd0, fetch_valid}, 32'd0);
        check("rst_wait_bt", {31'd0, branch_taken}, 32'd0);
`ifdef BRANCH_STATS_EN
        check("br_cnt_rst", br_cnt, 32'd0);
        check("taken_cnt_rst", taken_cnt, 32'd0);
`endif
        rst = 0; imem_ready = 1;
        step(); check("reboot_pc", pc, 32'h0); check("reboot_fv", {31'd0, fetch_valid}, 32'd1);
        step(); check("reboot_seq", pc, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
